move_seq: RTL and testbench
===========================

MOVE_SEQ -- requirements
Module: move_seq

Interface
REQ-001 Parameter NUM_REGS, default 5, number of general registers; one-hot enable width; range 2..64.
REQ-002 Parameter OP_MOV, default 4'b0100, opcode selecting register-to-register move.
REQ-003 Parameter OP_XCHG, default 4'b0101, opcode selecting register exchange; used only when MOVE_SEQ_XCHG_EN is defined.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 instruction  input  16  [15:12] opcode, [11:6] destination index, [5:0] source index.
REQ-007 done  output  1  one-cycle pulse when the operation completes.
REQ-008 pc_inc  output  1  one-cycle program-counter increment request.
REQ-009 rx_out  output  NUM_REGS  one-hot register read (bus-drive) enable.
REQ-010 rx_in  output  NUM_REGS  one-hot register write (bus-load) enable.
REQ-011 tmp_ld / tmp_out  output  1 each  load / drive internal temp register (exchange only).
REQ-012 err  output  1  one-cycle pulse on out-of-range register index.

Function
REQ-013 Moore outputs, decoded from present state and captured indices only; no instruction-to-output combinational path.
REQ-014 Index i maps to one-hot bit NUM_REGS-1-i; index >= NUM_REGS is invalid and maps to all zeros.
REQ-015 States: IDLE, FETCH, XFER, DONE, HOLD, ERR; plus X1, X2, X3 when exchange is enabled.
REQ-016 IDLE: all outputs 0; opcode = OP_MOV (or OP_XCHG when enabled) -> FETCH, capturing dst/src indices that clock.
REQ-017 Captured indices stay constant until next return to IDLE; instruction field changes mid-operation are ignored.
REQ-018 FETCH: pc_inc=1, other outputs 0; either captured index invalid -> ERR; else MOV -> XFER, XCHG -> X1.
REQ-019 XFER: rx_out=onehot(src), rx_in=onehot(dst) for exactly one cycle -> DONE.
REQ-020 X1: rx_out=onehot(src), tmp_ld=1 -> X2; X2: rx_out=onehot(dst), rx_in=onehot(src) -> X3; X3: tmp_out=1, rx_in=onehot(dst) -> DONE.
REQ-021 dst == src is legal: MOV performs a one-cycle self-move; XCHG runs all three steps unchanged.
REQ-022 DONE: done=1 -> HOLD; ERR: err=1 -> HOLD (done never asserted on error).
REQ-023 HOLD: all outputs 0; stays in HOLD while opcode remains the captured opcode.
REQ-024 Any state: opcode not equal to captured opcode at a clock edge -> IDLE next cycle, overriding other transitions; no partial enables persist.
REQ-025 Latency MOV: pc_inc cycle 1, transfer cycle 2, done cycle 3; XCHG: done cycle 5.
REQ-026 rx_in and rx_out are each one-hot or zero in every state; rx_in never equals rx_out except dst == src self-move.

Reset
REQ-027 rst low asynchronously forces IDLE, captured indices to 0, all outputs 0.
REQ-028 First state change after rst deassertion is synchronous to clk; reset mid-exchange abandons the sequence without further enables.

Configuration
REQ-029 Macro MOVE_SEQ_XCHG_EN defined: states X1..X3, tmp_ld/tmp_out, OP_XCHG decode present.
REQ-030 Macro undefined: OP_XCHG treated as non-matching opcode (stays IDLE); tmp_ld and tmp_out ports exist and tie to 0.

Structure
REQ-031 Shared package holds state encoding enum, opcode field positions, default OP_MOV/OP_XCHG constants.
REQ-032 One sub-module idx_onehot (index + NUM_REGS -> one-hot, valid flag), instantiated for src and dst.

Verification
REQ-033 Reset low mid-X2 -> all outputs 0 same cycle; IDLE after release; no done.
REQ-034 NUM_REGS=5, instruction 16'h4081 (dst 2, src 1) held -> pc_inc cycle 1; rx_out=5'b01000, rx_in=5'b00100 cycle 2; done cycle 3; HOLD thereafter.
REQ-035 instruction 16'h4145 (dst 5, src 5, invalid) -> pc_inc, then err=1, no rx_in/rx_out/done.
REQ-036 MOVE_SEQ_XCHG_EN, 16'h5040 (dst 1, src 0) -> tmp_ld with rx_out=10000; rx_out=01000/rx_in=10000; tmp_out with rx_in=01000; done cycle 5.
REQ-037 Opcode changed to 4'h0 during XFER cycle -> IDLE next cycle, no done; reapplying 16'h4081 restarts at FETCH.
REQ-038 NUM_REGS=8, dst=src=7 MOV -> rx_out=rx_in=8'b00000001 one cycle, done asserted.

Source files
------------

// File: rtl/move_seq_pkg.sv
// Shared definitions for the register-move sequencer: instruction field layout,
// default opcodes and the controller state encoding.
package move_seq_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 6;
  localparam int SRC_MSB = 5;
  localparam int SRC_LSB = 0;
  localparam int IDX_W   = 6;

  localparam logic [3:0] OP_MOV_DEF  = 4'b0100;
  localparam logic [3:0] OP_XCHG_DEF = 4'b0101;

  // X1..X3 are only reachable when the exchange feature is built in.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_XFER,
    ST_DONE,
    ST_HOLD,
    ST_ERR,
    ST_X1,
    ST_X2,
    ST_X3
  } state_t;

endpackage

// File: rtl/move_seq_idx_onehot.sv
// Register index to one-hot enable decoder; index i drives bit NUM_REGS-1-i,
// out-of-range indices give all zeros and a cleared valid flag.
module idx_onehot
  import move_seq_pkg::*;
#(
  parameter int NUM_REGS = 5
) (
  input  logic [IDX_W-1:0]    i_idx,
  output logic [NUM_REGS-1:0] o_onehot,
  output logic                o_valid
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_idx == IDX_W'(i)) o_onehot[NUM_REGS-1-i] = 1'b1;
    end
  end

  assign o_valid = (int'({26'd0, i_idx}) < NUM_REGS);

endmodule

// File: rtl/move_seq.sv
// Moore sequencer issuing one-hot bus enables for register MOV (and, with
// MOVE_SEQ_XCHG_EN defined, a three-step XCHG through a temp register).
module move_seq
  import move_seq_pkg::*;
#(
  parameter int         NUM_REGS = 5,
  parameter logic [3:0] OP_MOV   = OP_MOV_DEF,
  parameter logic [3:0] OP_XCHG  = OP_XCHG_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         instruction,
  output logic                done,
  output logic                pc_inc,
  output logic [NUM_REGS-1:0] rx_out,
  output logic [NUM_REGS-1:0] rx_in,
  output logic                tmp_ld,
  output logic                tmp_out,
  output logic                err
);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_op;
  logic [IDX_W-1:0]    r_dst;
  logic [IDX_W-1:0]    r_src;
  logic [3:0]          w_opc;
  logic                w_start;
  logic                w_is_xchg;
  logic [NUM_REGS-1:0] w_dst_oh;
  logic [NUM_REGS-1:0] w_src_oh;
  logic                w_dst_vld;
  logic                w_src_vld;

  assign w_opc = instruction[OPC_MSB:OPC_LSB];

`ifdef MOVE_SEQ_XCHG_EN
  assign w_start   = (w_opc == OP_MOV) || (w_opc == OP_XCHG);
  assign w_is_xchg = (r_op == OP_XCHG);
`else
  logic w_unused_xchg;
  assign w_unused_xchg = ^OP_XCHG;
  assign w_start       = (w_opc == OP_MOV);
  assign w_is_xchg     = 1'b0;
`endif

  idx_onehot #(.NUM_REGS(NUM_REGS)) u_dst_dec (
    .i_idx    (r_dst),
    .o_onehot (w_dst_oh),
    .o_valid  (w_dst_vld)
  );

  idx_onehot #(.NUM_REGS(NUM_REGS)) u_src_dec (
    .i_idx    (r_src),
    .o_onehot (w_src_oh),
    .o_valid  (w_src_vld)
  );

  // Operands are latched only on leaving IDLE so mid-operation field changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_dst   <= '0;
      r_src   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_start) begin
        r_op  <= w_opc;
        r_dst <= instruction[DST_MSB:DST_LSB];
        r_src <= instruction[SRC_MSB:SRC_LSB];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_FETCH;
      ST_FETCH: begin
        if (!w_src_vld || !w_dst_vld) w_next = ST_ERR;
        else if (w_is_xchg)           w_next = ST_X1;
        else                          w_next = ST_XFER;
      end
      ST_XFER:  w_next = ST_DONE;
`ifdef MOVE_SEQ_XCHG_EN
      ST_X1:    w_next = ST_X2;
      ST_X2:    w_next = ST_X3;
      ST_X3:    w_next = ST_DONE;
`endif
      ST_DONE:  w_next = ST_HOLD;
      ST_ERR:   w_next = ST_HOLD;
      ST_HOLD:  w_next = ST_HOLD;
      default:  w_next = ST_IDLE;
    endcase
    // An opcode change aborts whatever is in flight.
    if (r_state != ST_IDLE && w_opc != r_op) w_next = ST_IDLE;
  end

  always_comb begin
    done    = 1'b0;
    pc_inc  = 1'b0;
    err     = 1'b0;
    tmp_ld  = 1'b0;
    tmp_out = 1'b0;
    rx_out  = '0;
    rx_in   = '0;
    case (r_state)
      ST_FETCH: pc_inc = 1'b1;
      ST_XFER: begin
        rx_out = w_src_oh;
        rx_in  = w_dst_oh;
      end
`ifdef MOVE_SEQ_XCHG_EN
      ST_X1: begin
        rx_out = w_src_oh;
        tmp_ld = 1'b1;
      end
      ST_X2: begin
        rx_out = w_dst_oh;
        rx_in  = w_src_oh;
      end
      ST_X3: begin
        tmp_out = 1'b1;
        rx_in   = w_dst_oh;
      end
`endif
      ST_DONE:  done = 1'b1;
      ST_ERR:   err  = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_move_seq.sv
// Randomized bench for move_seq (NUM_REGS=5 and 8) against a script-based model,
// plus literal checks of the directed scenarios.
module tb_move_seq;

  localparam int N0 = 5;
  localparam int N1 = 8;
`ifdef MOVE_SEQ_XCHG_EN
  localparam bit XCHG_EN = 1'b1;
`else
  localparam bit XCHG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instruction = 16'h0000;

  logic          done5, pc5, tl5, to5, err5;
  logic [N0-1:0] ro5, ri5;
  logic          done8, pc8, tl8, to8, err8;
  logic [N1-1:0] ro8, ri8;

  move_seq #(.NUM_REGS(N0)) u_dut5 (
    .clk(clk), .rst(rst), .instruction(instruction),
    .done(done5), .pc_inc(pc5), .rx_out(ro5), .rx_in(ri5),
    .tmp_ld(tl5), .tmp_out(to5), .err(err5)
  );

  move_seq #(.NUM_REGS(N1)) u_dut8 (
    .clk(clk), .rst(rst), .instruction(instruction),
    .done(done8), .pc_inc(pc8), .rx_out(ro8), .rx_in(ri8),
    .tmp_ld(tl8), .tmp_out(to8), .err(err8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic        pc_inc;
    logic        err;
    logic        tmp_ld;
    logic        tmp_out;
    logic [63:0] rx_out;
    logic [63:0] rx_in;
  } obs_t;

  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: on accepting an instruction, the whole run of per-cycle outputs is
  // written out as a script; afterwards it is replayed, or dropped on opcode change.
  obs_t cur [2];
  obs_t scr [2][8];
  int   len [2];
  int   pos [2];
  bit   active [2];
  logic [3:0] capop [2];

  function automatic obs_t mk(bit d, bit p, bit e, bit tl, bit to,
                              logic [63:0] ro, logic [63:0] ri);
    obs_t o;
    o.done = d; o.pc_inc = p; o.err = e; o.tmp_ld = tl; o.tmp_out = to;
    o.rx_out = ro; o.rx_in = ri;
    return o;
  endfunction

  function automatic logic [63:0] oh(int idx, int n);
    if (idx < n) return 64'd1 << (n - 1 - idx);
    return 64'd0;
  endfunction

  task automatic model_reset(int k);
    active[k] = 1'b0;
    capop[k]  = 4'h0;
    len[k]    = 0;
    pos[k]    = 0;
    cur[k]    = '0;
  endtask

  task automatic push(int k, obs_t o);
    scr[k][len[k]] = o;
    len[k]++;
  endtask

  task automatic model_edge(int k, int n);
    logic [3:0] op;
    int d, s;
    op = instruction[15:12];
    d  = int'(instruction[11:6]);
    s  = int'(instruction[5:0]);
    if (!active[k]) begin
      if (op == 4'h4 || (XCHG_EN && op == 4'h5)) begin
        active[k] = 1'b1;
        capop[k]  = op;
        len[k]    = 0;
        push(k, mk(0, 1, 0, 0, 0, 0, 0));
        if (d >= n || s >= n) begin
          push(k, mk(0, 0, 1, 0, 0, 0, 0));
        end else begin
          if (op == 4'h4) begin
            push(k, mk(0, 0, 0, 0, 0, oh(s, n), oh(d, n)));
          end else begin
            push(k, mk(0, 0, 0, 1, 0, oh(s, n), 0));
            push(k, mk(0, 0, 0, 0, 0, oh(d, n), oh(s, n)));
            push(k, mk(0, 0, 0, 0, 1, 0, oh(d, n)));
          end
          push(k, mk(1, 0, 0, 0, 0, 0, 0));
        end
        cur[k] = scr[k][0];
        pos[k] = 1;
      end else begin
        cur[k] = '0;
      end
    end else if (op != capop[k]) begin
      active[k] = 1'b0;
      cur[k]    = '0;
    end else if (pos[k] < len[k]) begin
      cur[k] = scr[k][pos[k]];
      pos[k]++;
    end else begin
      cur[k] = '0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, N0);
      model_edge(1, N1);
    end
  end

  task automatic cmp_obs(int k, obs_t g, obs_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL model_cmp dut%0d t=%0t: got d=%b pc=%b e=%b tl=%b to=%b ro=%h ri=%h, expected d=%b pc=%b e=%b tl=%b to=%b ro=%h ri=%h",
               k, $time, g.done, g.pc_inc, g.err, g.tmp_ld, g.tmp_out, g.rx_out, g.rx_in,
               e.done, e.pc_inc, e.err, e.tmp_ld, e.tmp_out, e.rx_out, e.rx_in);
    end
  endtask

  always @(negedge clk) begin
    cmp_obs(0, mk(done5, pc5, err5, tl5, to5, 64'(ro5), 64'(ri5)), cur[0]);
    cmp_obs(1, mk(done8, pc8, err8, tl8, to8, 64'(ro8), 64'(ri8)), cur[1]);
  end

  task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    cyc(3);
    lit("rst_done", 64'(done5), 0);
    lit("rst_pc", 64'(pc5), 0);
    lit("rst_rx_out", 64'(ro5), 0);
    lit("rst_rx_in", 64'(ri5), 0);
    lit("rst_err", 64'(err5), 0);
    rst = 1'b1;
    cyc(1);

    // MOV dst 2 src 1
    instruction = 16'h4081;
    cyc(1); lit("mov_c1_pc", 64'(pc5), 1); lit("mov_c1_rx", 64'(ro5), 0);
    cyc(1); lit("mov_c2_rx_out", 64'(ro5), 64'b01000); lit("mov_c2_rx_in", 64'(ri5), 64'b00100);
            lit("mov_c2_done", 64'(done5), 0);
    cyc(1); lit("mov_c3_done", 64'(done5), 1);
    cyc(1); lit("mov_hold_done", 64'(done5), 0); lit("mov_hold_rx", 64'(ro5 | ri5), 0);
    cyc(2);
    instruction = 16'h0000;
    cyc(1);

    // Invalid index
    instruction = 16'h4145;
    cyc(1); lit("inv_pc", 64'(pc5), 1);
    cyc(1); lit("inv_err", 64'(err5), 1); lit("inv_rx", 64'(ro5 | ri5), 0);
            lit("inv_done", 64'(done5), 0);
    cyc(1); lit("inv_after_done", 64'(done5), 0); lit("inv_after_err", 64'(err5), 0);
    instruction = 16'h0000;
    cyc(1);

    // Abort during XFER, then restart
    instruction = 16'h4081;
    cyc(2); lit("abort_xfer_rx_in", 64'(ri5), 64'b00100);
    instruction = 16'h0081;
    cyc(1); lit("abort_done", 64'(done5), 0); lit("abort_rx", 64'(ro5 | ri5), 0);
    instruction = 16'h4081;
    cyc(1); lit("restart_pc", 64'(pc5), 1);
    cyc(1); lit("restart_rx_in", 64'(ri5), 64'b00100);
    cyc(1); lit("restart_done", 64'(done5), 1);
    instruction = 16'h0000;
    cyc(1);

    // Self-move on the 8-register instance, index 7 (invalid for 5 registers)
    instruction = 16'h41C7;
    cyc(1); lit("self8_pc", 64'(pc8), 1);
    cyc(1); lit("self8_rx_out", 64'(ro8), 64'h01); lit("self8_rx_in", 64'(ri8), 64'h01);
            lit("self5_err", 64'(err5), 1);
    cyc(1); lit("self8_done", 64'(done8), 1); lit("self5_done", 64'(done5), 0);
    instruction = 16'h0000;
    cyc(1);

    instruction = 16'h5040;
    if (XCHG_EN) begin
      cyc(1); lit("xchg_pc", 64'(pc5), 1);
      cyc(1); lit("xchg_x1_tmp_ld", 64'(tl5), 1); lit("xchg_x1_rx_out", 64'(ro5), 64'b10000);
              lit("xchg_x1_rx_in", 64'(ri5), 0);
      cyc(1); lit("xchg_x2_rx_out", 64'(ro5), 64'b01000); lit("xchg_x2_rx_in", 64'(ri5), 64'b10000);
      cyc(1); lit("xchg_x3_tmp_out", 64'(to5), 1); lit("xchg_x3_rx_in", 64'(ri5), 64'b01000);
      cyc(1); lit("xchg_done", 64'(done5), 1);
      instruction = 16'h0000;
      cyc(1);
      // Reset during X2
      instruction = 16'h5040;
      cyc(3);
    end else begin
      for (int i = 0; i < 3; i++) begin
        cyc(1); lit("xchg_off_pc", 64'(pc5), 0); lit("xchg_off_tmp", 64'(tl5 | to5), 0);
      end
      instruction = 16'h0000;
      cyc(1);
      // Reset during XFER
      instruction = 16'h4081;
      cyc(2);
    end
    #2 rst = 1'b0;
    #1;
    lit("midrst_rx_out", 64'(ro5), 0); lit("midrst_rx_in", 64'(ri5), 0);
    lit("midrst_tmp", 64'(tl5 | to5), 0);
    instruction = 16'h0000;
    cyc(1);
    rst = 1'b1;
    cyc(1); lit("midrst_after_done", 64'(done5), 0); lit("midrst_after_pc", 64'(pc5), 0);
    cyc(1); lit("midrst_after2_done", 64'(done5), 0);

    // Randomized phase
    for (int t = 0; t < 400; t++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 9);
      if (r <= 4)      op = 4'h4;
      else if (r <= 7) op = 4'h5;
      else if (r == 8) op = 4'h0;
      else             op = 4'($urandom_range(0, 15));
      instruction = {op, 6'($urandom_range(0, 9)), 6'($urandom_range(0, 9))};
      for (int h = $urandom_range(1, 8); h > 0; h--) begin
        cyc(1);
        if ($urandom_range(0, 3) == 0)
          instruction[11:0] = {6'($urandom_range(0, 9)), 6'($urandom_range(0, 9))};
      end
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b0;
        cyc(1);
        rst = 1'b1;
      end
    end
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
